lfsr_way_sel: RTL
=================

Name: lfsr_way_sel

Overview:
- Parametrised pseudo-random victim/way selector for set-associative caches and arbiters.
- Contains an XNOR-form maximal-length LFSR of selectable width with a seed-load port and lock-up recovery.
- Honours a per-way valid mask: a free way always wins; otherwise the LFSR picks a way, including for non-power-of-two way counts.
- Result is registered with a request/valid handshake and sits between the cache controller's miss handler and the tag/data arrays.

Parameters:
- LfsrWidth, 16: LFSR state width. Legal values are 8, 16, 24 and 32; anything else is an elaboration $fatal.
- NumWays, 8: number of selectable ways. Range is 2..2**min(LfsrWidth,8); outside that range is an elaboration $fatal.
- Seed, '0: reset and recovery state, LfsrWidth bits. All-ones is an elaboration $fatal.
- IdxW (derived), $clog2(NumWays): index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  free-running advance request.
- seed_load_i  in  1  load seed_i into the LFSR.
- seed_i  in  LfsrWidth  seed value.
- req_i  in  1  way-selection request.
- valid_mask_i  in  NumWays  bit w=1 means way w holds a valid line.
- way_valid_o  out  1  one-cycle pulse: result below is new.
- way_oh_o  out  NumWays  selected way, one-hot.
- way_bin_o  out  IdxW  selected way, binary.
- lockup_o  out  1  one-cycle pulse: lock-up state was detected and replaced.

Behaviour:
- Taps (1-based, XNOR feedback, shift toward the MSB, new bit enters at bit 0):
  - 8: 8,6,5,4
  - 16: 16,15,13,4
  - 24: 24,23,22,17
  - 32: 32,22,2,1
- shift_in = ~(XOR of the tapped bits); next = {state[LfsrWidth-2:0], shift_in}.
- Reset, applied asynchronously while rst_i is high:
  - state = Seed.
  - way_valid_o = 0, way_oh_o = 0, way_bin_o = 0, lockup_o = 0.
- State update each clock, highest priority first:
  1. seed_load_i=1: state <= seed_i. If seed_i is all-ones, state <= Seed instead and lockup_o pulses.
  2. Else if the current state is all-ones (lock-up): state <= Seed and lockup_o pulses. This case cannot arise from legal stepping; it is defensive.
  3. Else if en_i | req_i: state <= next. Advance at most once per cycle, even when both are high.
  4. Else: hold.
- Selection is combinational from the current-cycle state and valid_mask_i, registered when req_i=1:
  - If any valid_mask_i bit is 0: pick the lowest-index zero bit (free way).
  - Else: cand = state[IdxW-1:0]. If cand >= NumWays, cand = cand - NumWays; a single subtract suffices because 2**IdxW < 2*NumWays.
- Handshake:
  - req_i high in cycle N produces way_valid_o=1 in cycle N+1, with way_oh_o and way_bin_o updated at that edge. Latency is 1.
  - way_valid_o deasserts after one cycle unless req_i is high again; back-to-back requests give one result per cycle.
  - way_oh_o and way_bin_o hold their last values between requests.
  - way_oh_o always equals 1 << way_bin_o.
- Simultaneous events:
  - req_i with seed_load_i: the selection uses the pre-load state, and the LFSR takes seed_i, not next.
  - req_i in a lock-up cycle: the selection uses the lock-up state modulo NumWays, and the LFSR recovers to Seed.
- Reset mid-operation: all outputs return to 0 immediately and asynchronously; an in-flight request is dropped.
- No combinational path from any input to any output.

Test Plan:
- LfsrWidth=8, NumWays=4, Seed=0, mask=4'hF, req_i=1 every cycle from reset -> LFSR states 00,01,03,07,0F,1E; way_bin_o=0,1,3,3,3 starting the cycle after the first req; way_valid_o held high.
- LfsrWidth=8, NumWays=6, Seed=0, full mask, req_i=1 on the cycles when the state is 07, 0F and 1E -> raw candidates 7,7,6 give way_bin_o=1,1,0; way_oh_o=6'b000010, 6'b000010, 6'b000001.
- NumWays=4, mask=4'b1011, req_i at any LFSR state -> way_bin_o=2, way_oh_o=4'b0100; the LFSR still advances by one step.
- seed_load_i=1 with seed_i=8'h5A and req_i=1 in the same cycle -> result uses the old state; the state is 5A next cycle and B5 the cycle after with en_i=1 (8'hB4 | shift_in 1). seed_i=8'hFF -> state=Seed, lockup_o=1 for exactly one cycle.
- Force the state to all-ones via backdoor -> next cycle state=Seed, lockup_o pulses once, no X on any output.
- rst_i asserted asynchronously mid-cycle while way_valid_o=1 -> all outputs 0 before the next edge; after release, the LFSR restarts from Seed and the first req gives way_bin_o=Seed[IdxW-1:0].

Source files
------------

// File: rtl/lfsr_way_sel.sv
// Pseudo-random victim/way selector: an XNOR maximal-length LFSR with lock-up
// recovery plus a free-way-first picker. The selected way is registered on request.
module lfsr_way_sel #(
  parameter int unsigned          LfsrWidth = 16,
  parameter int unsigned          NumWays   = 8,
  parameter logic [LfsrWidth-1:0] Seed      = '0,
  localparam int unsigned         IdxW      = $clog2(NumWays)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 seed_load_i,
  input  logic [LfsrWidth-1:0] seed_i,
  input  logic                 req_i,
  input  logic [NumWays-1:0]   valid_mask_i,
  output logic                 way_valid_o,
  output logic [NumWays-1:0]   way_oh_o,
  output logic [IdxW-1:0]      way_bin_o,
  output logic                 lockup_o
);

  localparam int unsigned MinW    = (LfsrWidth < 8) ? LfsrWidth : 8;
  localparam int unsigned MaxWays = 1 << MinW;

  if (!(LfsrWidth inside {8, 16, 24, 32})) begin : g_bad_width
    $fatal(1, "lfsr_way_sel: LfsrWidth must be 8, 16, 24 or 32");
  end
  if (NumWays < 2 || NumWays > MaxWays) begin : g_bad_ways
    $fatal(1, "lfsr_way_sel: NumWays out of range");
  end
  if (Seed == {LfsrWidth{1'b1}}) begin : g_bad_seed
    $fatal(1, "lfsr_way_sel: Seed must not be all-ones (XNOR lock-up state)");
  end

  localparam logic [31:0] TapMask32 =
    (LfsrWidth == 8)  ? 32'h0000_00B8 :
    (LfsrWidth == 16) ? 32'h0000_D008 :
    (LfsrWidth == 24) ? 32'h00E1_0000 : 32'h8020_0003;
  localparam logic [LfsrWidth-1:0] TapMask = TapMask32[LfsrWidth-1:0];
  localparam logic [IdxW:0]        WaysExt = NumWays[IdxW:0];

  logic [LfsrWidth-1:0] r_state;
  logic                 r_valid;
  logic [NumWays-1:0]   r_oh;
  logic [IdxW-1:0]      r_bin;
  logic                 r_lockup;

  logic                 w_all_ones;
  logic                 w_seed_bad;
  logic                 w_shift_in;
  logic [LfsrWidth-1:0] w_next;
  logic                 w_has_free;
  logic [IdxW-1:0]      w_free_idx;
  logic [IdxW:0]        w_cand_ext;
  logic [IdxW-1:0]      w_cand;
  logic [IdxW-1:0]      w_sel;
  logic [NumWays-1:0]   w_oh;

  assign w_all_ones = &r_state;
  assign w_seed_bad = &seed_i;
  assign w_shift_in = ~^(r_state & TapMask);
  assign w_next     = {r_state[LfsrWidth-2:0], w_shift_in};

  // Descending scan so the lowest-index free way is the one left standing.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int w = NumWays - 1; w >= 0; w--) begin
      if (!valid_mask_i[w]) begin
        w_has_free = 1'b1;
        w_free_idx = IdxW'(w);
      end
    end
  end

  // 2**IdxW < 2*NumWays, so one conditional subtract folds the raw index into range.
  always_comb begin
    w_cand_ext = {1'b0, r_state[IdxW-1:0]};
    if (w_cand_ext >= WaysExt) begin
      w_cand = IdxW'(w_cand_ext - WaysExt);
    end else begin
      w_cand = w_cand_ext[IdxW-1:0];
    end
  end

  always_comb begin
    w_sel       = w_has_free ? w_free_idx : w_cand;
    w_oh        = '0;
    w_oh[w_sel] = 1'b1;
  end

  // Handshake: req_i sampled at edge N gives way_valid_o high for the cycle after
  // that edge, with way_oh_o/way_bin_o updated at the same edge and held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= Seed;
      r_valid  <= 1'b0;
      r_oh     <= '0;
      r_bin    <= '0;
      r_lockup <= 1'b0;
    end else begin
      r_valid  <= req_i;
      r_lockup <= 1'b0;
      if (req_i) begin
        r_oh  <= w_oh;
        r_bin <= w_sel;
      end
      if (seed_load_i) begin
        if (w_seed_bad) begin
          r_state  <= Seed;
          r_lockup <= 1'b1;
        end else begin
          r_state <= seed_i;
        end
      end else if (w_all_ones) begin
        r_state  <= Seed;
        r_lockup <= 1'b1;
      end else if (en_i || req_i) begin
        r_state <= w_next;
      end
    end
  end

  assign way_valid_o = r_valid;
  assign way_oh_o    = r_oh;
  assign way_bin_o   = r_bin;
  assign lockup_o    = r_lockup;

endmodule
